// File: rtl/rx_phy_pkg.sv
// Shared PHY symbol definitions for the receive sync controller and the IDLE/COM serializer.
package rx_phy_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] IDL_SYM = 8'h7C;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_SYNC  = 2'd2
  } state_t;

  // Payload is anything other than the two link-control symbols.
  function automatic logic is_payload(input logic [7:0] sym);
    return (sym != COM_SYM) && (sym != IDL_SYM);
  endfunction

endpackage

// File: rtl/rx_symbol_shifter.sv
// Serial-to-parallel shifter with a loadable mod-8 bit counter and symbol compare flags.
module rx_symbol_shifter
  import rx_phy_pkg::*;
(
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  input  logic       cnt_load,
  output logic [7:0] sr,
  output logic [2:0] cnt,
  output logic       is_com,
  output logic       is_idl
);

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      sr  <= 8'h00;
      cnt <= 3'd0;
    end else begin
      sr <= {sr[6:0], data_in};
      // Loading 1 makes cnt wrap to 0 exactly when the next full byte sits in sr.
      cnt <= cnt_load ? 3'd1 : cnt + 3'd1;
    end
  end

  assign is_com = (sr == COM_SYM);
  assign is_idl = (sr == IDL_SYM);

endmodule

// File: rtl/rx_sync_controller.sv
// Receive link sync controller: hunts for COM at any bit offset, locks byte alignment, then deserializes.
module rx_sync_controller
  import rx_phy_pkg::*;
#(
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic       active,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic [1:0] state_dbg
);

  localparam logic [3:0] SYNC_TARGET = 4'(SYNC_COUNT);

  state_t     state;
  logic [3:0] com_cnt;
  logic [7:0] sr;
  logic [2:0] cnt;
  logic       is_com;
  logic       is_idl;
  logic       cnt_load;
  logic       boundary;

  assign cnt_load = (state == ST_HUNT) && is_com;
  assign boundary = (cnt == 3'd0);

  rx_symbol_shifter u_shifter (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .cnt_load (cnt_load),
    .sr       (sr),
    .cnt      (cnt),
    .is_com   (is_com),
    .is_idl   (is_idl)
  );

  // Output protocol: byte_strobe is a single-cycle pulse with no back-pressure; data_out and
  // valid_out change only on a strobe and hold their value until the next one.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state       <= ST_HUNT;
      com_cnt     <= 4'd0;
      active      <= 1'b0;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (is_com) begin
            com_cnt <= 4'd1;
            if (SYNC_COUNT == 1) begin
              state  <= ST_SYNC;
              active <= 1'b1;
            end else begin
              state <= ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          if (boundary) begin
            if (is_com) begin
              com_cnt <= com_cnt + 4'd1;
              if (com_cnt + 4'd1 == SYNC_TARGET) begin
                state  <= ST_SYNC;
                active <= 1'b1;
              end
            end else begin
              // Broken run: start over; this byte is not re-examined as a fresh COM.
              state   <= ST_HUNT;
              com_cnt <= 4'd0;
            end
          end
        end
        ST_SYNC: begin
          if (boundary) begin
            data_out    <= sr;
            valid_out   <= is_payload(sr);
            byte_strobe <= 1'b1;
          end
        end
        default: begin
          state   <= ST_HUNT;
          com_cnt <= 4'd0;
          active  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_rx_sync_controller.sv
// Directed bench for rx_sync_controller: reset, aligned/offset sync, broken runs, symbol classes, mid-byte reset.
module tb_rx_sync_controller;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic       active;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk_32f = ~clk_32f;

  rx_sync_controller #(.SYNC_COUNT(4)) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .active      (active),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .state_dbg   (state_dbg)
  );

  // Drive one bit, let the next posedge sample it, then settle 1 time unit past the edge.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic apply_reset();
    reset   = 1'b0;
    data_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    data_in = 1'b1;
    repeat (3) @(posedge clk_32f);
    #1;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active got %0b exp 0", active); end
    checks++; if (byte_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe got %0b exp 0", byte_strobe); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", data_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", valid_out); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_dbg); end
    reset = 1'b1;
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    checks++; if (state_dbg !== 2'd0 || active !== 1'b0) begin errors++;
      $display("FAIL rst_idle_ones got state %0d active %0b exp 0 0", state_dbg, active); end
  endtask

  task automatic test_aligned_sync();
    apply_reset();
    send_byte(8'hBC);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL t2_hunt got %0d exp 0", state_dbg); end
    send_bit(1'b1);  // MSB of second BC; first COM is recognised on this edge
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL t2_align got %0d exp 1", state_dbg); end
    for (int i = 6; i >= 0; i--) send_bit(8'hBC >> i);
    send_byte(8'hBC);
    send_byte(8'hBC);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL t2_active_early got %0b exp 0", active); end
    send_bit(1'b1);  // A5 MSB
    checks++; if (active !== 1'b1 || state_dbg !== 2'd2) begin errors++;
      $display("FAIL t2_active got active %0b state %0d exp 1 2", active, state_dbg); end
    for (int i = 6; i >= 0; i--) begin
      send_bit(8'hA5 >> i);
      checks++; if (byte_strobe !== 1'b0) begin errors++; $display("FAIL t2_no_strobe bit %0d got %0b exp 0", i, byte_strobe); end
    end
  endtask

  // Continues the synced stream from test_aligned_sync; each byte's first bit reveals the previous byte.
  task automatic test_payload_classes();
    logic [7:0] tx [4];
    logic [7:0] exp_data [4];
    logic       exp_valid [4];
    tx = '{8'h7C, 8'hBC, 8'h01, 8'h00};
    exp_data = '{8'hA5, 8'h7C, 8'hBC, 8'h01};
    exp_valid = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      send_bit(tx[k][7]);
      checks++; if (byte_strobe !== 1'b1 || data_out !== exp_data[k] || valid_out !== exp_valid[k]) begin errors++;
        $display("FAIL t5_byte%0d got strobe %0b data %h valid %0b exp 1 %h %0b",
                 k, byte_strobe, data_out, valid_out, exp_data[k], exp_valid[k]); end
      for (int i = 6; i >= 0; i--) send_bit(tx[k][i]);
      checks++; if (byte_strobe !== 1'b0 || data_out !== exp_data[k]) begin errors++;
        $display("FAIL t5_hold%0d got strobe %0b data %h exp 0 %h", k, byte_strobe, data_out, exp_data[k]); end
    end
  endtask

  task automatic test_offset_sync();
    apply_reset();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (4) send_byte(8'hBC);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL t3_active_early got %0b exp 0", active); end
    send_byte(8'h3C);
    checks++; if (active !== 1'b1 || byte_strobe !== 1'b0) begin errors++;
      $display("FAIL t3_locked got active %0b strobe %0b exp 1 0", active, byte_strobe); end
    send_bit(1'b1);  // first bit of 8'hC3
    checks++; if (byte_strobe !== 1'b1 || data_out !== 8'h3C || valid_out !== 1'b1) begin errors++;
      $display("FAIL t3_byte got strobe %0b data %h valid %0b exp 1 3c 1", byte_strobe, data_out, valid_out); end
    for (int i = 6; i >= 0; i--) send_bit(8'hC3 >> i);
    checks++; if (byte_strobe !== 1'b0) begin errors++; $display("FAIL t3_gap got %0b exp 0", byte_strobe); end
    send_bit(1'b0);  // 8 cycles after the previous strobe
    checks++; if (byte_strobe !== 1'b1 || data_out !== 8'hC3) begin errors++;
      $display("FAIL t3_period got strobe %0b data %h exp 1 c3", byte_strobe, data_out); end
  endtask

  task automatic test_broken_run();
    apply_reset();
    repeat (3) send_byte(8'hBC);
    send_byte(8'h55);
    send_bit(1'b1);
    checks++; if (state_dbg !== 2'd0 || active !== 1'b0) begin errors++;
      $display("FAIL t4_broken got state %0d active %0b exp 0 0", state_dbg, active); end
    for (int i = 6; i >= 0; i--) send_bit(8'hBC >> i);
    repeat (3) send_byte(8'hBC);
    checks++; if (active !== 1'b0 || state_dbg !== 2'd1) begin errors++;
      $display("FAIL t4_rerun got active %0b state %0d exp 0 1", active, state_dbg); end
    send_bit(1'b0);
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL t4_sync got %0b exp 1", active); end
  endtask

  task automatic test_mid_byte_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    reset = 1'b0;
    @(posedge clk_32f);
    #1;
    checks++; if (active !== 1'b0 || byte_strobe !== 1'b0 || data_out !== 8'h00 || state_dbg !== 2'd0) begin errors++;
      $display("FAIL t6_reset got active %0b strobe %0b data %h state %0d exp 0 0 00 0",
               active, byte_strobe, data_out, state_dbg); end
    @(posedge clk_32f);
    #1;
    reset = 1'b1;
    repeat (3) send_byte(8'hBC);
    send_bit(1'b1);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL t6_three_com got %0b exp 0", active); end
    for (int i = 6; i >= 0; i--) send_bit(8'hBC >> i);
    send_bit(1'b0);
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL t6_resync got %0b exp 1", active); end
  endtask

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;
    test_reset();
    test_aligned_sync();
    test_payload_classes();
    test_offset_sync();
    test_broken_run();
    test_mid_byte_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
